// File: rtl/wb_fuente_poller.sv
// Wishbone master that walks a run of wb_fuente addresses: set addr_rd, pulse rd, read d_out.
// Each entry is four single-beat transfers with one idle bus cycle after each.
module wb_fuente_poller #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          PERIOD   = 1000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        auto_i,
    input  logic [7:0]  cfg_first_i,
    input  logic [7:0]  cfg_count_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [31:0] sample_o,
    output logic [7:0]  sample_adr_o,
    output logic        sample_valid_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SET_ADR, S_RD_HI, S_RD_LO, S_READ, S_GAP, S_NEXT
    } state_t;

    state_t      r_state, w_state, r_ret, w_ret;
    logic [7:0]  r_cur, w_cur, r_rem, w_rem;
    logic [PW-1:0] r_per;
    logic [TW-1:0] r_to;
    logic        r_cyc, r_stb, r_we;
    logic [31:0] r_adr, r_dat;
    logic [31:0] r_sample, w_sample;
    logic [7:0]  r_sample_adr, w_sample_adr;
    logic        r_sval, w_sval, r_done, w_done, r_err, w_err;
    logic        w_bus_go, w_bus_drop, w_bus_we, w_per_hit, w_trig;
    logic [31:0] w_bus_adr, w_bus_dat;

    assign w_per_hit = (r_per == PW'(PERIOD - 1));
    assign w_trig    = start_i || (auto_i && w_per_hit);

    always_comb begin
        w_state      = r_state;
        w_ret        = r_ret;
        w_cur        = r_cur;
        w_rem        = r_rem;
        w_sample     = r_sample;
        w_sample_adr = r_sample_adr;
        w_sval       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_bus_go     = 1'b0;
        w_bus_drop   = 1'b0;
        case (r_state)
            S_IDLE: if (w_trig) begin
                w_cur = cfg_first_i;
                w_rem = cfg_count_i;
                if (cfg_count_i == 8'd0) begin
                    w_done = 1'b1;
                end else begin
                    w_state  = S_SET_ADR;
                    w_bus_go = 1'b1;
                end
            end
            S_SET_ADR, S_RD_HI, S_RD_LO, S_READ: begin
                if (wbm_ack_i) begin
                    w_bus_drop = 1'b1;
                    case (r_state)
                        S_SET_ADR: begin w_state = S_GAP; w_ret = S_RD_HI; end
                        S_RD_HI:   begin w_state = S_GAP; w_ret = S_RD_LO; end
                        S_RD_LO:   begin w_state = S_GAP; w_ret = S_READ;  end
                        default: begin
                            // NEXT doubles as the idle cycle after the read
                            w_state      = S_NEXT;
                            w_sample     = wbm_dat_i;
                            w_sample_adr = r_cur;
                            w_sval       = 1'b1;
                        end
                    endcase
                end else if (r_to == TW'(TIMEOUT - 1)) begin
                    w_bus_drop = 1'b1;
                    w_err      = 1'b1;
                    w_state    = S_IDLE;
                end
            end
            S_GAP: begin
                w_state  = r_ret;
                w_bus_go = 1'b1;
            end
            S_NEXT: begin
                w_rem = r_rem - 8'd1;
                w_cur = r_cur + 8'd1;
                if (r_rem == 8'd1) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_state  = S_SET_ADR;
                    w_bus_go = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Bus fields for the transfer being entered.
    always_comb begin
        w_bus_we  = 1'b0;
        w_bus_adr = 32'h0;
        w_bus_dat = 32'h0;
        case (w_state)
            S_SET_ADR: begin w_bus_we = 1'b1; w_bus_adr = BASE_ADR + 32'h4; w_bus_dat = {24'h0, w_cur}; end
            S_RD_HI:   begin w_bus_we = 1'b1; w_bus_adr = BASE_ADR;         w_bus_dat = 32'h1; end
            S_RD_LO:   begin w_bus_we = 1'b1; w_bus_adr = BASE_ADR;         w_bus_dat = 32'h0; end
            S_READ:    begin w_bus_we = 1'b0; w_bus_adr = BASE_ADR + 32'h8; w_bus_dat = 32'h0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ret        <= S_IDLE;
            r_cur        <= 8'h0;
            r_rem        <= 8'h0;
            r_per        <= '0;
            r_to         <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= 32'h0;
            r_dat        <= 32'h0;
            r_sample     <= 32'h0;
            r_sample_adr <= 8'h0;
            r_sval       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_ret        <= w_ret;
            r_cur        <= w_cur;
            r_rem        <= w_rem;
            r_per        <= (!auto_i || w_per_hit) ? '0 : r_per + 1'b1;
            if (w_bus_go) begin
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_we  <= w_bus_we;
                r_adr <= w_bus_adr;
                r_dat <= w_bus_dat;
                r_to  <= '0;
            end else if (w_bus_drop) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
                r_we  <= 1'b0;
                r_adr <= 32'h0;
                r_dat <= 32'h0;
            end else if (r_stb) begin
                r_to  <= r_to + 1'b1;
            end
            r_sample     <= w_sample;
            r_sample_adr <= w_sample_adr;
            r_sval       <= w_sval;
            r_done       <= w_done;
            r_err        <= w_err;
        end
    end

    assign wbm_cyc_o      = r_cyc;
    assign wbm_stb_o      = r_stb;
    assign wbm_we_o       = r_we;
    assign wbm_adr_o      = r_adr;
    assign wbm_dat_o      = r_dat;
    assign wbm_sel_o      = r_stb ? 4'hF : 4'h0;
    assign sample_o       = r_sample;
    assign sample_adr_o   = r_sample_adr;
    assign sample_valid_o = r_sval;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign busy_o         = (r_state != S_IDLE);
endmodule

// File: doc/wb_fuente_poller.md
Name: wb_fuente_poller

Overview:
- Wishbone master sequencer that autonomously drives the wb_fuente slave.
- Per entry, in order: write read address to addr_rd (0x04), pulse rd (write 1 then 0 to 0x00), read d_out (0x08).
- Scans a configurable run of addresses, one-shot or periodically, and presents each sample to downstream LCD/pH logic, so the CPU never has to bit-bang the fuente registers.

Parameters:
- BASE_ADR, 32'h00000000, base address of wb_fuente; register offsets 0x00/0x04/0x08 are added to it.
- PERIOD, 1000, cycles between scan starts in auto mode; minimum 2.
- TIMEOUT, 16, cycles a strobe may stay unacknowledged before the transfer is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; begins a scan when IDLE.
- auto_i  in  1  level; 1 = rescan every PERIOD cycles.
- cfg_first_i  in  8  first address written to addr_rd.
- cfg_count_i  in  8  number of entries per scan; 0 = no-op scan.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  32  address.
- wbm_sel_o  out  4  byte select; always 4'hF when stb=1, else 0.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- sample_o  out  32  last d_out value read.
- sample_adr_o  out  8  address that produced sample_o.
- sample_valid_o  out  1  one-cycle pulse when sample_o updates.
- done_o  out  1  one-cycle pulse at scan end.
- err_o  out  1  one-cycle pulse on timeout abort.
- busy_o  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state=IDLE; entry index=0; period counter=0.
- States: IDLE, SET_ADR, RD_HI, RD_LO, READ, GAP, NEXT.
- IDLE:
  - Scan trigger = start_i=1, or auto_i=1 with period counter reaching PERIOD-1.
  - On trigger: load cur_adr=cfg_first_i and remaining=cfg_count_i.
  - If remaining=0: pulse done_o the next cycle and stay IDLE.
  - Otherwise go to SET_ADR.
- Period counter:
  - Free-runs only while auto_i=1; held at 0 while auto_i=0.
  - Wraps to 0 at PERIOD-1.
  - A trigger arriving while busy is dropped, not queued.
- Bus transfer, identical mechanics in SET_ADR, RD_HI, RD_LO and READ:
  - On state entry, cyc/stb/we/adr/dat/sel are registered and held stable until ack.
  - SET_ADR: we=1, adr=BASE+0x04, dat={24'h0,cur_adr}.
  - RD_HI: we=1, adr=BASE+0x00, dat=1.
  - RD_LO: we=1, adr=BASE+0x00, dat=0.
  - READ: we=0, adr=BASE+0x08, dat=0.
  - When ack=1 is sampled on a rising edge, cyc/stb/we drop on that same edge; adr/dat return to 0.
  - After every acked transfer the FSM spends exactly one cycle in GAP (bus idle), then moves to the next state in sequence.
  - Minimum transfer is 2 cycles (strobe plus GAP), so one entry takes at least 8 cycles.
- READ ack:
  - sample_o<=wbm_dat_i and sample_adr_o<=cur_adr on the ack edge.
  - sample_valid_o pulses on the following cycle.
- NEXT:
  - remaining-1 and cur_adr+1; cur_adr wraps 8'hFF to 8'h00.
  - If remaining reaches 0: pulse done_o and return to IDLE; otherwise go to SET_ADR.
- Timeout:
  - A per-transfer counter is cleared on every strobe start.
  - If it reaches TIMEOUT-1 with no ack, drop cyc/stb, pulse err_o, abort the whole scan and return to IDLE (no done_o).
  - An ack in the same cycle the counter reaches its limit wins; no error.
- Stable config: cfg_* are sampled only at scan start; changes mid-scan have no effect.
- auto_i falling mid-scan: the current scan completes.
- Reset mid-transfer: the bus is released immediately (async); no partial sample is reported.
- sample_o holds its value until the next READ ack.

Test Plan:
- Single scan: cfg_first=8'h38, count=1, pulse start, slave acks in 1 cycle -> bus sequence (0x04,W,0x38), (0x00,W,1), (0x00,W,0), (0x08,R); sample_o=slave data, sample_adr_o=0x38, one sample_valid_o pulse, then done_o; busy for 8 cycles.
- Multi-entry with wrap: first=8'hFE, count=3 -> addr_rd writes 0xFE, 0xFF, 0x00; three sample_valid_o pulses, one done_o.
- Slave wait states: ack delayed 5 cycles on READ -> stb held, adr=BASE+0x08 stable for 5 cycles, no err_o; captured value equals dat_i at the ack edge.
- Timeout: TIMEOUT=16, slave never acks RD_HI -> stb high for 16 cycles, err_o pulse, busy_o=0, no done_o.
- Auto mode: PERIOD=100, count=1, auto_i=1 -> scans start every 100 cycles; start_i pulse while busy is ignored; count=0 -> done_o only, no bus activity.
- Async reset asserted while stb=1 -> cyc/stb/busy drop without a clock edge; after release the FSM is in IDLE with all outputs 0.
